// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin arbiter sharing one divider among NUM_REQ requesters
// Optional watchdog on the divider wait: define DIV_ARB_TIMEOUT_EN
module div_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 40,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_dividend,
  input  logic [NUM_REQ*DW-1:0] req_divisor,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_quotient,
  output logic [DW-1:0]         rsp_remainder,
  output logic                  rsp_divzero,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [IW-1:0]         grant_id,
  output logic                  div_start,
  output logic [DW-1:0]         div_dividend,
  output logic [DW-1:0]         div_divisor,
  input  logic [DW-1:0]         div_quotient,
  input  logic [DW-1:0]         div_remainder,
  input  logic                  div_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] rr_ptr;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          accept;
  logic          wait_done;
  logic          wait_expired;

  assign accept    = (state == S_IDLE) && win_found;
  assign wait_done = (state == S_WAIT) && div_valid;

  // Round-robin pick: first pending requester at or above rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i >= NUM_REQ) ? IW'(int'(rr_ptr) + i - NUM_REQ)
                                           : IW'(int'(rr_ptr) + i);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] wait_cnt;

  // A real div_valid on the expiry cycle takes precedence over the abort
  assign wait_expired = (state == S_WAIT) && !div_valid && (wait_cnt == CW'(TIMEOUT - 1));

  // Watchdog counts WAIT cycles, cleared while issuing so each job starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Timeout flag follows the most recent capture: set on abort, cleared on a real result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_timeout <= 1'b0;
    end else if (wait_done) begin
      rsp_timeout <= 1'b0;
    end else if (wait_expired) begin
      rsp_timeout <= 1'b1;
    end
  end
`else
  // Without the watchdog WAIT blocks until div_valid and TIMEOUT has no effect
  assign wait_expired = 1'b0;
  assign rsp_timeout  = 1'b0;
  if (TIMEOUT < 1) begin : g_timeout_inert
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-state strobes; accept pulse is held off while in reset
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    div_start = 1'b0;
    rsp_valid = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = ~rst;
          state_nx           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (wait_done || wait_expired) begin
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[grant_id] = 1'b1;
        state_nx            = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latch on accept, result capture in WAIT, pointer advance in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id      <= '0;
      rr_ptr        <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_divzero   <= 1'b0;
    end else begin
      if (accept) begin
        grant_id     <= win_idx;
        div_dividend <= req_dividend[int'(win_idx)*DW +: DW];
        div_divisor  <= req_divisor[int'(win_idx)*DW +: DW];
      end
      if (wait_done) begin
        rsp_quotient  <= div_quotient;
        rsp_remainder <= div_remainder;
        rsp_divzero   <= (div_divisor == '0);
      end else if (wait_expired) begin
        rsp_quotient  <= '0;
        rsp_remainder <= '0;
        rsp_divzero   <= 1'b0;
      end
      if (state == S_RESP) begin
        rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - self-checking bench for div_share_arbiter with a stub divider
module tb_div_share_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int TO = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_dividend = '0;
  logic [NR*DW-1:0]  req_divisor = '0;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_quotient, rsp_remainder;
  logic              rsp_divzero, rsp_timeout, busy, div_start;
  logic [IW-1:0]     grant_id;
  logic [DW-1:0]     div_dividend, div_divisor;
  logic [DW-1:0]     div_quotient = '0;
  logic [DW-1:0]     div_remainder = '0;
  logic              div_valid = 1'b0;

  always #5 clk = ~clk;

  div_share_arbiter #(.NUM_REQ(NR), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_divzero(rsp_divzero), .rsp_timeout(rsp_timeout), .busy(busy), .grant_id(grant_id),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_valid(div_valid)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stub divider: valid 17 cycles after start (1 for a zero divisor); stall suppresses it
  int            dcnt = 0;
  logic [DW-1:0] d_a, d_b;
  bit            stall = 1'b0;
  always @(negedge clk) begin
    div_valid = 1'b0;
    if (rst) begin
      dcnt = 0;
    end else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_valid     = 1'b1;
          div_quotient  = (d_b == 0) ? '0 : d_a / d_b;
          div_remainder = (d_b == 0) ? d_a : d_a % d_b;
        end
      end
      if (div_start && !stall) begin
        d_a  = div_dividend;
        d_b  = div_divisor;
        dcnt = (d_b == 0) ? 1 : 17;
      end
    end
  end

  // Client side: per-requester job queues {dividend, divisor}
  logic [31:0]   jq [NR][$];
  logic [NR-1:0] ready_seen = '0;

  task automatic drive();
    logic [31:0] h;
    for (int i = 0; i < NR; i++) begin
      if (jq[i].size() > 0) begin
        h = jq[i][0];
        req_valid[i] = 1'b1;
        req_dividend[i*DW +: DW] = h[31:16];
        req_divisor[i*DW +: DW]  = h[15:0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (ready_seen[i] && jq[i].size() > 0) void'(jq[i].pop_front());
    drive();
  endtask

  // Behavioural model: job timing from accept cycle, results from plain arithmetic
  bit            job_act = 1'b0;
  int            j_acc, j_resp, j_id, rr, w;
  logic [DW-1:0] j_a, j_b;
  bit            j_to;
  logic [DW-1:0] e_q, e_r, e_dd, e_ds;
  logic          e_dz, e_to, e_busy, e_start;
  logic [IW-1:0] e_gid;
  logic [NR-1:0] e_ready, e_rsp;

  int            acc_n = 0;
  int            rsp_n = 0;
  int            acc_cyc [64];
  int            acc_id  [64];
  int            rsp_cyc [64];
  int            rsp_id  [64];
  logic [DW-1:0] rsp_q   [64];
  logic [DW-1:0] rsp_r   [64];
  logic          rsp_dz  [64];
  logic          rsp_to  [64];

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    e_ready = '0;
    if (rst) begin
      job_act = 1'b0;
      rr = 0;
      e_q = '0; e_r = '0; e_dd = '0; e_ds = '0;
      e_dz = 1'b0; e_to = 1'b0; e_gid = '0;
    end else begin
      if (job_act && cyc > j_resp) job_act = 1'b0;
      if (!job_act && req_valid != '0) begin
        w = -1;
        for (int k = 0; k < NR; k++)
          if (w < 0 && req_valid[(rr + k) % NR]) w = (rr + k) % NR;
        job_act = 1'b1;
        j_acc   = cyc;
        j_id    = w;
        j_a     = req_dividend[w*DW +: DW];
        j_b     = req_divisor[w*DW +: DW];
        j_to    = stall;
        j_resp  = j_to ? cyc + 2 + TO : ((j_b == 0) ? cyc + 3 : cyc + 19);
        e_ready = NR'(1) << w;
      end
      if (job_act && cyc == j_acc + 1) begin
        e_gid = IW'(j_id);
        e_dd  = j_a;
        e_ds  = j_b;
      end
      if (job_act && cyc == j_resp) begin
        if (j_to) begin
          e_q = '0; e_r = '0; e_dz = 1'b0; e_to = 1'b1;
        end else begin
          e_q  = (j_b == 0) ? '0 : j_a / j_b;
          e_r  = (j_b == 0) ? j_a : j_a % j_b;
          e_dz = (j_b == 0);
          e_to = 1'b0;
        end
        rr = (j_id + 1) % NR;
      end
    end
    e_busy  = job_act && cyc > j_acc;
    e_start = job_act && cyc == j_acc + 1;
    e_rsp   = (job_act && cyc == j_resp) ? NR'(1) << j_id : '0;

    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("div_start", 32'(div_start), 32'(e_start));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("rsp_quotient", 32'(rsp_quotient), 32'(e_q));
    chk("rsp_remainder", 32'(rsp_remainder), 32'(e_r));
    chk("rsp_divzero", 32'(rsp_divzero), 32'(e_dz));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
    chk("grant_id", 32'(grant_id), 32'(e_gid));
    chk("div_dividend", 32'(div_dividend), 32'(e_dd));
    chk("div_divisor", 32'(div_divisor), 32'(e_ds));

    if (req_ready != '0 && acc_n < 64) begin
      acc_cyc[acc_n] = cyc;
      acc_id[acc_n]  = onehot_idx(req_ready);
      acc_n++;
    end
    if (rsp_valid != '0 && rsp_n < 64) begin
      rsp_cyc[rsp_n] = cyc;
      rsp_id[rsp_n]  = onehot_idx(rsp_valid);
      rsp_q[rsp_n]   = rsp_quotient;
      rsp_r[rsp_n]   = rsp_remainder;
      rsp_dz[rsp_n]  = rsp_divzero;
      rsp_to[rsp_n]  = rsp_timeout;
      rsp_n++;
    end
    ready_seen = req_ready;
    cyc++;
  end

  task automatic run_until_rsp(input int n);
    int k;
    k = 0;
    while (rsp_n < n && k < 400) begin
      step();
      k++;
    end
    chk("rsp_count_reached", 32'(rsp_n >= n), 32'd1);
    step();
  endtask

  int fair_exp [6] = '{2, 0, 2, 0, 2, 0};
  int t_acc, k;

  initial begin
    // Contention: all four requesters pending straight out of reset
    jq[0].push_back({16'd1000, 16'd10});
    jq[1].push_back({16'd77, 16'd5});
    jq[2].push_back({16'hFFFF, 16'd1});
    jq[3].push_back({16'd5, 16'd9});
    drive();
    repeat (3) step();
    rst = 1'b0;
    run_until_rsp(4);
    for (int i = 0; i < 4; i++) begin
      chk("contention_grant_order", 32'(acc_id[i]), 32'(i));
      chk("contention_rsp_owner", 32'(rsp_id[i]), 32'(i));
    end
    chk("contention_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd20);
    chk("contention_q0", 32'(rsp_q[0]), 32'd100);
    chk("contention_q1", {rsp_q[1], rsp_r[1]}, {16'd15, 16'd2});
    chk("contention_q2", {rsp_q[2], rsp_r[2]}, {16'hFFFF, 16'd0});
    chk("contention_q3", {rsp_q[3], rsp_r[3]}, {16'd0, 16'd5});

    // Single job after rr_ptr wrapped from 3 back to 0
    jq[0].push_back({16'd100, 16'd7});
    drive();
    run_until_rsp(5);
    chk("single_grant", 32'(acc_id[4]), 32'd0);
    chk("single_latency", 32'(rsp_cyc[4] - acc_cyc[4]), 32'd19);
    chk("single_q", 32'(rsp_q[4]), 32'd14);
    chk("single_r", 32'(rsp_r[4]), 32'd2);
    chk("single_dz", 32'(rsp_dz[4]), 32'd0);

    // Fairness: requesters 0 and 2 continuously pending, pointer starts at 1
    for (int i = 0; i < 3; i++) begin
      jq[0].push_back({16'(40 + i), 16'd3});
      jq[2].push_back({16'(500 + i), 16'd11});
    end
    drive();
    run_until_rsp(11);
    for (int i = 0; i < 6; i++) chk("fair_grant", 32'(acc_id[5 + i]), 32'(fair_exp[i]));
    chk("fair_q_first", {rsp_q[5], rsp_r[5]}, {16'd45, 16'd5});

    // Divide by zero on requester 1
    jq[1].push_back({16'h1234, 16'd0});
    drive();
    run_until_rsp(12);
    chk("dz_grant", 32'(acc_id[11]), 32'd1);
    chk("dz_latency", 32'(rsp_cyc[11] - acc_cyc[11]), 32'd3);
    chk("dz_result", {rsp_q[11], rsp_r[11]}, {16'd0, 16'h1234});
    chk("dz_flag", 32'(rsp_dz[11]), 32'd1);

    // Reset in cycle T+8 of a job, then a fresh job
    jq[2].push_back({16'd1000, 16'd3});
    drive();
    k = 0;
    while (acc_n < 13 && k < 50) begin
      step();
      k++;
    end
    chk("reset_job_accepted", 32'(acc_n), 32'd13);
    t_acc = acc_cyc[12];
    k = 0;
    while (cyc < t_acc + 8 && k < 50) begin
      step();
      k++;
    end
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();
    chk("reset_no_rsp", 32'(rsp_n), 32'd12);
    jq[1].push_back({16'd200, 16'd10});
    drive();
    run_until_rsp(13);
    chk("post_reset_grant", 32'(rsp_id[12]), 32'd1);
    chk("post_reset_result", {rsp_q[12], rsp_r[12]}, {16'd20, 16'd0});
    chk("post_reset_latency", 32'(rsp_cyc[12] - acc_cyc[13]), 32'd19);

`ifdef DIV_ARB_TIMEOUT_EN
    // Divider never answers: watchdog must abort after TO wait cycles
    stall = 1'b1;
    jq[3].push_back({16'd50, 16'd5});
    drive();
    run_until_rsp(14);
    chk("to_flag", 32'(rsp_to[13]), 32'd1);
    chk("to_result", {rsp_q[13], rsp_r[13]}, 32'd0);
    chk("to_latency", 32'(rsp_cyc[13] - acc_cyc[14]), 32'(TO + 2));
    stall = 1'b0;
    jq[0].push_back({16'd9, 16'd3});
    drive();
    run_until_rsp(15);
    chk("after_to", {16'(rsp_q[14]), 15'd0, rsp_to[14]}, {16'd3, 16'd0});
`endif

    chk("one_rsp_per_job", 32'(acc_n - rsp_n), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got %0d checks, expected completion", n_total);
    $fatal(1);
  end

endmodule
